axis2buffer: RTL and testbench
==============================

Name: axis2buffer

Overview:
- AXI4-Stream slave that receives one row of WIDTH pixel words and converts each pixel to a single cell bit by comparing it against alive_color.
- Presents the packed WIDTH-bit row to the conware computation core through a valid/ready handshake.
- Sits on the input side of the core: it turns the pixel stream back into the cell rows that the core's output converter emits.
- Checks row framing on TLAST, drops malformed rows, resynchronises to the next frame boundary, and counts errors.

Parameters:
- DWIDTH, 32, pixel word width (S_AXIS_TDATA, alive_color).
- WIDTH, 4, cells per row and beats per AXIS packet; legal range 2..255.
- EWIDTH, 8, width of the error counter.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- alive_color  in  DWIDTH  pixel value that decodes to cell=1; any other value decodes to 0.
- S_AXIS_TDATA  in  DWIDTH  pixel word.
- S_AXIS_TVALID  in  1  beat valid.
- S_AXIS_TREADY  out  1  beat accept.
- S_AXIS_TLAST  in  1  last beat of the row.
- out_data  out  WIDTH  packed row; bit i = pixel i, where beat 0 maps to bit 0.
- out_valid  out  1  row available to the core.
- out_ready  in  1  core accepts the row.
- frame_err  out  1  one-cycle pulse when a row is dropped.
- err_count  out  EWIDTH  saturating count of dropped rows.

Behaviour:
- Beat = S_AXIS_TVALID & S_AXIS_TREADY. Row handshake = out_valid & out_ready.
- All outputs are registered or decoded from registered state only; there is no combinational path from AXIS inputs to S_AXIS_TREADY.
- Reset (rstn=0 at posedge):
  - state=RECV, counter=0, shift/assembly register=0.
  - out_data=0, out_valid=0, frame_err=0, err_count=0.
  - S_AXIS_TREADY is forced to 0 while rstn=0.
- Reset mid-row or mid-present discards all partial and pending data; there is no output for that row.
- States:
  - RECV: TREADY=1, out_valid=0. On each beat, assembly bit[counter] <= (TDATA == alive_color).
    - counter<WIDTH-1 and TLAST=0: counter+1, stay RECV.
    - counter<WIDTH-1 and TLAST=1 (short row): discard row, counter=0, frame_err pulse, err_count+1, stay RECV.
    - counter==WIDTH-1 and TLAST=1: out_data <= assembled row including this beat's bit, counter=0, go PRESENT.
    - counter==WIDTH-1 and TLAST=0 (long row): discard row, counter=0, frame_err pulse, err_count+1, go DRAIN.
    - No beat: hold everything.
  - PRESENT: out_valid=1, TREADY=0.
    - out_data stays stable until the handshake completes.
    - On handshake: out_valid deasserts the next cycle, go RECV.
    - Without out_ready: hold indefinitely; the stream is back-pressured.
  - DRAIN: TREADY=1, beats are discarded and not decoded.
    - On a beat with TLAST=1: go RECV, counter=0.
    - No further error is counted for the drained beats.
- Latency: out_valid rises on the cycle after the final (TLAST) beat is accepted.
- Throughput: one row per WIDTH+1 cycles minimum. The cycle after a row handshake, TREADY=1.
- err_count saturates at 2^EWIDTH-1. frame_err still pulses when err_count is saturated.
- TDATA, TLAST and alive_color are sampled only on beats. alive_color may change between beats; each beat uses the value present at its accept edge.
- An upstream TVALID drop mid-row is legal: the counter holds and no timeout applies.

Test Plan:
- Nominal, WIDTH=4, alive=0x00FFFFFF, dead=0: beats alive,dead,dead,alive with TLAST on beat 3 and out_ready=1 -> out_valid=1 one cycle after beat 3, out_data=4'b1001, out_valid=0 the following cycle, TREADY=1 again.
- Back-pressure: row 1111 with out_ready held 0 for 10 cycles, TVALID held 1 carrying the next row -> TREADY=0 and out_data=4'b1111 stable for all 10 cycles; after out_ready=1, the next row is accepted starting the following cycle.
- Short row: 2 beats alive,alive with TLAST on beat 1, then a valid row dead,alive,dead,dead -> frame_err pulses once, err_count=1, only out_data=4'b0010 is presented.
- Long row: 6 beats with TLAST only on beat 5, then a valid row -> frame_err pulses after beat 3, beats 4-5 are drained, err_count=1, the next row decodes correctly.
- Non-matching pixels: beats 0x00FFFFFE, 0x00FFFFFF, 0x12345678, 0x00FFFFFF -> out_data=4'b1010.
- Reset mid-row after 2 beats, then a full row 0110 -> no output for the partial row, out_data=4'b0110, err_count=0; with EWIDTH=2 and 5 short rows injected, err_count=3 (saturated).

Source files
------------

// File: rtl/axis2buffer.sv
// AXI4-Stream slave that thresholds one row of WIDTH pixels against alive_color
// and hands the packed cell row to the core over a valid/ready handshake.
module axis2buffer #(
   parameter int DWIDTH = 32,
   parameter int WIDTH  = 4,
   parameter int EWIDTH = 8
)(
   input  logic              clk,
   input  logic              rstn,
   input  logic [DWIDTH-1:0] alive_color,
   input  logic [DWIDTH-1:0] S_AXIS_TDATA,
   input  logic              S_AXIS_TVALID,
   output logic              S_AXIS_TREADY,
   input  logic              S_AXIS_TLAST,
   output logic [WIDTH-1:0]  out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              frame_err,
   output logic [EWIDTH-1:0] err_count
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   typedef enum logic [1:0] {RECV, PRESENT, DRAIN} state_t;

   state_t            state_q;
   logic [CW-1:0]     cnt_q;
   logic [WIDTH-1:0]  asm_q;
   logic [WIDTH-1:0]  asm_d;
   logic [WIDTH-1:0]  out_data_q;
   logic              out_valid_q;
   logic              frame_err_q;
   logic [EWIDTH-1:0] err_q;
   logic [EWIDTH-1:0] err_d;
   logic              beat;
   logic              pix_bit;

   // Ready depends only on state and reset, never on the incoming stream.
   assign S_AXIS_TREADY = rstn && (state_q != PRESENT);
   assign beat          = S_AXIS_TVALID & S_AXIS_TREADY;
   assign pix_bit       = (S_AXIS_TDATA == alive_color);

   always_comb begin
      asm_d        = asm_q;
      asm_d[cnt_q] = pix_bit;
   end

   assign err_d = (err_q == {EWIDTH{1'b1}}) ? err_q : err_q + 1'b1;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= RECV;
         cnt_q       <= '0;
         asm_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         err_q       <= '0;
      end else begin
         frame_err_q <= 1'b0;
         case (state_q)
            RECV: begin
               if (beat) begin
                  asm_q <= asm_d;
                  if (cnt_q == LAST_IDX) begin
                     cnt_q <= '0;
                     if (S_AXIS_TLAST) begin
                        out_data_q  <= asm_d;
                        out_valid_q <= 1'b1;
                        state_q     <= PRESENT;
                     end else begin
                        // Long row: the tail is swallowed up to the next TLAST.
                        frame_err_q <= 1'b1;
                        err_q       <= err_d;
                        state_q     <= DRAIN;
                     end
                  end else if (S_AXIS_TLAST) begin
                     cnt_q       <= '0;
                     frame_err_q <= 1'b1;
                     err_q       <= err_d;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            PRESENT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= RECV;
               end
            end
            DRAIN: begin
               if (beat && S_AXIS_TLAST) begin
                  cnt_q   <= '0;
                  state_q <= RECV;
               end
            end
            default: state_q <= RECV;
         endcase
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign frame_err = frame_err_q;
   assign err_count = err_q;
endmodule

// File: tb/tb_axis2buffer.sv
// Directed bench for axis2buffer: nominal rows, back-pressure, framing errors,
// reset recovery and error-counter saturation on a narrow-counter instance.
module tb_axis2buffer;
   localparam logic [31:0] ALIVE = 32'h00FF_FFFF;
   localparam logic [31:0] DEAD  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] alive_color = ALIVE;
   logic [31:0] tdata = '0;
   logic        tvalid = 1'b0;
   logic        tlast = 1'b0;
   logic        out_ready = 1'b1;
   logic        tready, out_valid, frame_err;
   logic [3:0]  out_data;
   logic [7:0]  err_count;
   logic        tready2, out_valid2, frame_err2;
   logic [3:0]  out_data2;
   logic [1:0]  err_count2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   axis2buffer #(.DWIDTH(32), .WIDTH(4), .EWIDTH(8)) dut (
      .clk(clk), .rstn(rstn), .alive_color(alive_color),
      .S_AXIS_TDATA(tdata), .S_AXIS_TVALID(tvalid), .S_AXIS_TREADY(tready),
      .S_AXIS_TLAST(tlast), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .frame_err(frame_err), .err_count(err_count)
   );

   axis2buffer #(.DWIDTH(32), .WIDTH(4), .EWIDTH(2)) dut_sat (
      .clk(clk), .rstn(rstn), .alive_color(alive_color),
      .S_AXIS_TDATA(tdata), .S_AXIS_TVALID(tvalid), .S_AXIS_TREADY(tready2),
      .S_AXIS_TLAST(tlast), .out_data(out_data2), .out_valid(out_valid2),
      .out_ready(out_ready), .frame_err(frame_err2), .err_count(err_count2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the beat was accepted.
   task automatic beat(input logic [31:0] d, input logic l);
      int n = 0;
      tvalid = 1'b1;
      tdata  = d;
      tlast  = l;
      while (!tready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("beat_timeout", 32'd1, 32'd0);
      @(negedge clk);
      tvalid = 1'b0;
      tlast  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_tready", tready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_err_count", err_count, 0);
      rstn = 1'b1;
      @(negedge clk);
      chk("post_rst_tready", tready, 1);

      // Nominal row alive,dead,dead,alive
      beat(ALIVE, 0); beat(DEAD, 0); beat(DEAD, 0); beat(ALIVE, 1);
      chk("nom_out_valid", out_valid, 1);
      chk("nom_out_data", out_data, 4'b1001);
      chk("nom_tready_present", tready, 0);
      @(negedge clk);
      chk("nom_out_valid_drop", out_valid, 0);
      chk("nom_tready_back", tready, 1);

      // Back-pressure with row 1111
      out_ready = 1'b0;
      beat(ALIVE, 0); beat(ALIVE, 0); beat(ALIVE, 0); beat(ALIVE, 1);
      tvalid = 1'b1; tdata = DEAD; tlast = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk("bp_tready", tready, 0);
         chk("bp_out_data", out_data, 4'b1111);
         chk("bp_out_valid", out_valid, 1);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_released_valid", out_valid, 0);
      chk("bp_released_tready", tready, 1);
      beat(DEAD, 0); beat(DEAD, 0); beat(ALIVE, 0); beat(DEAD, 1);
      chk("bp_next_row", out_data, 4'b0100);
      chk("bp_next_valid", out_valid, 1);
      @(negedge clk);

      // Short row then valid row dead,alive,dead,dead
      beat(ALIVE, 0); beat(ALIVE, 1);
      chk("short_frame_err", frame_err, 1);
      chk("short_err_count", err_count, 1);
      chk("short_no_valid", out_valid, 0);
      @(negedge clk);
      chk("short_frame_err_pulse", frame_err, 0);
      beat(DEAD, 0); beat(ALIVE, 0); beat(DEAD, 0); beat(DEAD, 1);
      chk("short_next_row", out_data, 4'b0010);
      chk("short_next_valid", out_valid, 1);
      @(negedge clk);

      // Long row of 6 beats then valid row alive,alive,dead,alive
      beat(ALIVE, 0); beat(ALIVE, 0); beat(ALIVE, 0);
      chk("long_no_err_early", frame_err, 0);
      beat(ALIVE, 0);
      chk("long_frame_err", frame_err, 1);
      chk("long_err_count", err_count, 2);
      beat(DEAD, 0);
      chk("long_drain_no_err", frame_err, 0);
      beat(ALIVE, 1);
      chk("long_drain_no_valid", out_valid, 0);
      chk("long_err_hold", err_count, 2);
      beat(ALIVE, 0); beat(ALIVE, 0); beat(DEAD, 0); beat(ALIVE, 1);
      chk("long_next_row", out_data, 4'b1011);
      chk("long_next_valid", out_valid, 1);
      @(negedge clk);

      // Non-matching pixels
      beat(32'h00FF_FFFE, 0); beat(32'h00FF_FFFF, 0);
      beat(32'h1234_5678, 0); beat(32'h00FF_FFFF, 1);
      chk("nonmatch_row", out_data, 4'b1010);
      @(negedge clk);

      // Reset mid-row, then row 0110
      beat(ALIVE, 0); beat(ALIVE, 0);
      rstn = 1'b0;
      #1;
      chk("midrst_tready", tready, 0);
      @(negedge clk);
      chk("midrst_out_data", out_data, 0);
      chk("midrst_err_count", err_count, 0);
      rstn = 1'b1;
      @(negedge clk);
      beat(DEAD, 0); beat(ALIVE, 0); beat(ALIVE, 0); beat(DEAD, 1);
      chk("midrst_row", out_data, 4'b0110);
      chk("midrst_valid", out_valid, 1);
      chk("midrst_err_zero", err_count, 0);
      @(negedge clk);

      // Five short rows: 2-bit counter saturates at 3
      for (int r = 0; r < 5; r++) begin
         beat(ALIVE, 0); beat(ALIVE, 1);
      end
      chk("sat_frame_err_pulse", frame_err2, 1);
      chk("sat_err_count2", err_count2, 3);
      chk("sat_err_count8", err_count, 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
